// File: rtl/interboard_sender.sv
// Board-to-board message transmitter: latches one 8-bit message and delivers it over a
// four-phase request/acknowledge handshake with per-phase timeout and bounded retry.
module interboard_sender #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  input  logic       rx_ack,
  output logic       tx_request,
  output logic [2:0] tx_msg_type,
  output logic [4:0] tx_number,
  output logic       inter_ready,
  output logic       busy,
  output logic       link_error
);

  localparam int unsigned PW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [2:0] TYPE_RSVD = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    DONE,
    RECOVER
  } state_t;

  state_t        state, state_n;
  logic          ack_meta, ack_s;
  logic [PW-1:0] phase_cnt, phase_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [2:0]    type_n;
  logic [4:0]    number_n;
  logic          link_error_n;
  logic          timeout;
  logic          restart;
  logic          clear;

  assign clear = rst | interboard_rst;

  // Two-flop synchronizer for the far board's acknowledge.
  always_ff @(posedge clk) begin
    if (clear) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= rx_ack;
      ack_s    <= ack_meta;
    end
  end

  always_comb begin
    state_n      = state;
    retry_n      = retry_cnt;
    type_n       = tx_msg_type;
    number_n     = tx_number;
    link_error_n = link_error;
    restart      = 1'b0;
    phase_n      = '0;
    timeout      = (phase_cnt == PW'(TIMEOUT_CYCLES - 1));

    case (state)
      IDLE: begin
        if (ctrl_en && (ctrl_msg_type != TYPE_RSVD)) begin
          type_n   = ctrl_msg_type;
          number_n = ctrl_number;
          retry_n  = '0;
          state_n  = ack_s ? RECOVER : REQ_HI;
        end
      end
      REQ_HI:  if (ack_s)  state_n = REQ_LO;
      REQ_LO:  if (!ack_s) state_n = DONE;
      RECOVER: if (!ack_s) state_n = REQ_HI;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A phase that neither advanced nor completed in time is retried or abandoned.
    if ((state inside {REQ_HI, REQ_LO, RECOVER}) && (state_n == state) && timeout) begin
      if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_n = retry_cnt + RW'(1);
        state_n = RECOVER;
        restart = 1'b1;
      end else begin
        link_error_n = 1'b1;
        state_n      = IDLE;
      end
    end

    if ((state_n == state) && !restart && (state inside {REQ_HI, REQ_LO, RECOVER})) begin
      phase_n = (phase_cnt == '1) ? phase_cnt : phase_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      retry_cnt   <= '0;
      tx_request  <= 1'b0;
      tx_msg_type <= 3'd0;
      tx_number   <= 5'd0;
      inter_ready <= 1'b0;
      busy        <= 1'b0;
      link_error  <= 1'b0;
    end else begin
      state       <= state_n;
      phase_cnt   <= phase_n;
      retry_cnt   <= retry_n;
      tx_request  <= (state_n == REQ_HI);
      tx_msg_type <= type_n;
      tx_number   <= number_n;
      inter_ready <= (state_n == DONE);
      busy        <= (state_n != IDLE);
      link_error  <= link_error_n;
    end
  end

endmodule

// File: doc/interboard_sender.md
# interboard_sender

Board-to-board message transmitter that sits between a game controller's `ctrl_en` / `ctrl_msg_type` / `ctrl_number` outputs and the interboard cable. It latches one 8-bit message, presents it on parallel pins under a four-phase request/acknowledge handshake, and pulses `inter_ready` once the far board has fully acknowledged. A per-phase timeout with bounded retry keeps a game FSM from hanging forever on a dead link.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 1_000_000: cycles allowed per handshake phase before the phase is aborted.
- `MAX_RETRY`, default 3: number of retransmissions after the first attempt before giving up.

Ports:

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `interboard_rst`  in  1  synchronous, active-high; identical effect to `rst`.
- `ctrl_en`  in  1  one-cycle strobe: accept the message on `ctrl_msg_type` / `ctrl_number`.
- `ctrl_msg_type`  in  3  message type (`STATE_TURN`, `SEL_NUM`, `STATE_WIN`); 3'b111 is reserved.
- `ctrl_number`  in  5  payload, 0–31.
- `rx_ack`  in  1  acknowledge from the far board; asynchronous to `clk`.
- `tx_request`  out  1  request to the far board.
- `tx_msg_type`  out  3  message type on the pins.
- `tx_number`  out  5  payload on the pins.
- `inter_ready`  out  1  one-cycle pulse: the message was delivered.
- `busy`  out  1  high from message acceptance until the sender returns to IDLE.
- `link_error`  out  1  sticky; set when all retries are exhausted.

## Operation

- `rx_ack` passes through a 2-flop synchronizer to produce `ack_s`. All decisions use `ack_s` only.
- All outputs are registered. Reset values: every output 0; state IDLE; all counters 0.

States and transitions:

- **IDLE**
  - On `ctrl_en` with type ≠ 3'b111: latch type and number, set `busy`, clear the retry count.
  - If `ack_s` = 0: go to REQ_HI.
  - If `ack_s` = 1 (stale ack): go to RECOVER first.
  - `ctrl_en` with type 3'b111 is ignored.
- **REQ_HI**
  - `tx_request` = 1; latched data driven on `tx_msg_type` / `tx_number`.
  - On `ack_s` = 1: go to REQ_LO.
- **REQ_LO**
  - `tx_request` = 0; data held.
  - On `ack_s` = 0: go to DONE.
- **DONE**
  - `inter_ready` = 1 for exactly this cycle.
  - `busy` = 0 next cycle; go to IDLE.
- **RECOVER**
  - `tx_request` = 0.
  - On `ack_s` = 0: go to REQ_HI.

Timeout and retry:

- The phase counter clears on every state entry and increments each cycle spent in REQ_HI, REQ_LO or RECOVER.
- Reaching `TIMEOUT_CYCLES`-1 is a timeout. On timeout, retry count < `MAX_RETRY` means: increment the retry count and go to RECOVER (the same message is resent).
- On timeout with the retry count = `MAX_RETRY`: set `link_error`, go to IDLE, clear `busy`, and do not pulse `inter_ready`.
- A timeout that occurs while already in RECOVER also consumes a retry.

Boundary conditions:

- `ctrl_en` while `busy`: ignored. The latched message is unchanged and nothing is queued.
- `ctrl_en` in the same cycle as DONE: ignored, because `busy` is still 1.
- `rst` or `interboard_rst` mid-handshake: next cycle `tx_request` = 0, outputs are cleared, state is IDLE, and `link_error` is cleared. No `inter_ready` is issued.
- `tx_msg_type` / `tx_number` remain stable from the first REQ_HI cycle through DONE. They keep their last value while idle and are never 3'b111.
- Counter widths:
  - Phase counter: $clog2(`TIMEOUT_CYCLES`+1) bits.
  - Retry counter: $clog2(`MAX_RETRY`+1) bits.
  - Neither counter wraps.

## Timing

- The `ctrl_en` cycle is T. Outputs:
  - T+1: `busy` = 1.
  - T+1: `tx_request` = 1 and data valid, if `ack_s` was 0 at T.
- If `rx_ack` rises at pin cycle A, `ack_s` = 1 at A+2 and `tx_request` falls at A+3.
- If `rx_ack` falls at pin cycle B:
  - `ack_s` = 0 at B+2.
  - DONE at B+3, which is when `inter_ready` pulses.
  - `busy` falls at B+4.
- Minimum T-to-`inter_ready` latency against a zero-delay responder: 7 cycles.
- The far board must sample data only after synchronizing `tx_request` high. Data leads or coincides with the request rise, so it is stable for at least 2 of its cycles.

## Test plan

- **Normal delivery:** `ctrl_en` with type `SEL_NUM`, number 17; responder raises ack 4 cycles after request and drops it 4 cycles after request falls -> pins show `SEL_NUM` / 17 throughout, one `inter_ready` pulse, `busy` low the following cycle, `link_error` = 0.
- **Overrun:** second `ctrl_en` (`STATE_WIN`, 3) 2 cycles after the first (`STATE_TURN`, 5) -> pins stay `STATE_TURN` / 5 and only one `inter_ready` pulse is seen.
- **Dead link:** `TIMEOUT_CYCLES` = 16, `MAX_RETRY` = 2, ack never rises -> 3 request pulses each lasting 16 cycles, then `link_error` = 1, `busy` = 0, no `inter_ready`.
- **Stale ack:** `rx_ack` held high; `ctrl_en` fires; ack released 10 cycles later -> `tx_request` stays 0 until `ack_s` = 0, then a normal handshake completes.
- **Reset mid-handshake:** `rst` asserted one cycle while in REQ_HI -> next cycle `tx_request` = 0, `busy` = 0, all outputs 0; no `inter_ready` afterwards.
- **Reserved type:** `ctrl_en` with type 3'b111 -> no request, `busy` stays 0.
